chunked_serial_adder: RTL and testbench
=======================================

# chunked_serial_adder

Multi-cycle N-bit adder/subtractor that processes its operands W bits per clock, LSB chunk first, and carries between chunks in a register. It is the sequential, parametrised successor to the team's combinational ripple-carry adder. It trades latency for a W-bit carry chain, so wide adds close timing in the datapath. Start/busy/done handshake; results held until the next operation completes.

## Interface
- N, 32, operand/result width in bits
- W, 8, chunk width processed per cycle; N must be a multiple of W (elaboration error otherwise)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0: a+b+c_in; 1: a-b (c_in ignored, carry-in forced 1)
- c_in  input  1  carry-in for add mode
- a  input  N  operand A, captured at accepted start
- b  input  N  operand B, captured at accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result registers just updated
- sum  output  N  result
- c_out  output  1  carry out of bit N-1 (sub mode: 1 = no borrow)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- Two states: IDLE (busy=0), RUN (busy=1). Chunk counter cnt is 0..N/W-1.
- IDLE:
  - On start=1, the block loads a into A_sh and (sub ? ~b : b) into B_sh.
  - It sets carry to (sub ? 1 : c_in), clears cnt to 0 and moves to RUN.
  - If start=0, nothing changes.
- RUN, each edge:
  - Computes {cy, s} = A_sh[W-1:0] + B_sh[W-1:0] + carry.
  - Shifts s into the top of an internal result shift register.
  - Shifts A_sh and B_sh right by W and sets carry to cy.
  - On the last chunk (cnt = N/W-1), it also captures the carry into bit N-1 for ovf.
- Last chunk edge:
  - sum is set to the completed result and c_out to the final cy.
  - ovf is set to (carry into MSB) XOR cy.
  - done=1, busy=0, state returns to IDLE.
- sum, c_out and ovf change only at completion. They hold their values during RUN and in IDLE.
- start while busy=1 is ignored; it is not queued.
- a, b, sub and c_in are don't-care except at the accepted start edge.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, state IDLE, all internal registers 0.
- Reset is asynchronous. Asserting rst_n mid-RUN aborts the operation immediately, and no done pulse follows.
- Latency: with start accepted at edge k, done=1 and results are valid after edge k+N/W.
- busy=1 from edge k+1 through edge k+N/W-1, and falls at edge k+N/W.
- done is high for exactly one cycle.
- start asserted in the done cycle is accepted at the next edge, giving back-to-back operations. Throughput is one operation per N/W+1 cycles.
- W=N: single chunk. Latency is 1 cycle and busy never asserts; done follows start by one edge.
- W=1: pure bit-serial operation with latency N.
- Arithmetic is modulo 2^N. Only c_out and ovf indicate range exceptions.

## Test plan
- N=8, W=4, add: a=0x3C, b=0x45, c_in=1, start for 1 cycle -> done 2 cycles later; sum=0x82, c_out=0, ovf=1; busy high for exactly 1 cycle.
- N=8, W=4, carry across chunks: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0. Then sub a=0x10, b=0x20 -> sum=0xF0, c_out=0, ovf=0.
- N=8, W=4, signed overflow in sub: a=0x80, b=0x01, sub=1 -> sum=0x7F, c_out=1, ovf=1.
- N=8, W=2, handshake:
  - start held high continuously with new operands each cycle -> operations accepted every 5 cycles.
  - Operand changes while busy are ignored.
  - Results are stable between done pulses.
- Reset mid-operation: N=32, W=8, rst_n low 2 cycles after start -> all outputs 0 immediately, no done pulse. A following start 0x0000FFFF+0x00000001 gives 0x00010000 after 4 cycles.
- Parameter sweep (N,W) in {(32,32), (32,1), (16,4)}: 1000 random add/sub operations checked against a behavioural model of sum, c_out and ovf, with done latency = N/W.

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for chunked_serial_adder.
//   start, sub, c_in, a, b : request side, driven by the master
//   busy, done, sum, c_out, ovf : status/result side, driven by the adder
interface chunked_serial_adder_if #(
   parameter int unsigned N = 32
);
   logic         start;
   logic         sub;
   logic         c_in;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         c_out;
   logic         ovf;

   modport master (
      output start, sub, c_in, a, b,
      input  busy, done, sum, c_out, ovf
   );

   modport slave (
      input  start, sub, c_in, a, b,
      output busy, done, sum, c_out, ovf
   );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle N-bit adder/subtractor working W bits per clock, LSB chunk first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of chunked_serial_adder_if
//           (start/sub/c_in/a/b in; busy/done/sum/c_out/ovf out, all registered)
module chunked_serial_adder #(
   parameter int unsigned N = 32,
   parameter int unsigned W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   chunked_serial_adder_if.slave bus
);
   localparam int unsigned NCH  = N / W;
   localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   if ((N % W) != 0) begin : g_bad_width
      $error("chunked_serial_adder: N must be a multiple of W");
   end

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic [N-1:0]  res_q, res_d;
   logic [N-1:0]  sum_q, sum_d;
   logic          c_out_q, c_out_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   logic [W:0]    chunk;     // {carry out, chunk sum}
   logic [N+W-1:0] res_cat;  // new chunk on top of the partial result
   logic          c_msb;     // carry into the top bit of the current chunk

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, chunk arithmetic and output updates
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      res_d   = res_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      busy_d  = 1'b0;

      chunk   = (W+1)'(a_q[W-1:0]) + (W+1)'(b_q[W-1:0]) + (W+1)'(carry_q);
      res_cat = {chunk[W-1:0], res_q};
      // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
      c_msb   = chunk[W-1] ^ a_q[W-1] ^ b_q[W-1];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.c_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> W;
            b_d     = b_q >> W;
            carry_d = chunk[W];
            res_d   = res_cat[N+W-1:W];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               sum_d   = res_cat[N+W-1:W];
               c_out_d = chunk[W];
               ovf_d   = c_msb ^ chunk[W];
               done_d  = 1'b1;
            end else begin
               // busy is visible only from the second processing edge onward
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;
   assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder over several (N,W) configurations.
module tb_chunked_serial_adder;
   localparam int NCFG = 6;

   // Configuration table: 0:(8,4) 1:(8,2) 2:(32,8) 3:(32,32) 4:(32,1) 5:(16,4)
   function automatic int unsigned cfg_n(int i);
      case (i)
         0, 1:    return 8;
         5:       return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int unsigned cfg_w(int i);
      case (i)
         0, 5:    return 4;
         1:       return 2;
         2:       return 8;
         3:       return 32;
         default: return 1;
      endcase
   endfunction

   typedef struct packed {
      logic [31:0] sum;
      logic        c_out;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;

   logic        start_v [NCFG];
   logic        sub_v   [NCFG];
   logic        cin_v   [NCFG];
   logic [31:0] a_v     [NCFG];
   logic [31:0] b_v     [NCFG];
   logic        busy_v  [NCFG];
   logic        done_v  [NCFG];
   logic        cout_v  [NCFG];
   logic        ovf_v   [NCFG];
   logic [31:0] sum_v   [NCFG];

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int unsigned GN = cfg_n(g);
      localparam int unsigned GW = cfg_w(g);
      chunked_serial_adder_if #(.N(GN)) bus ();
      chunked_serial_adder #(.N(GN), .W(GW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
      assign bus.start = start_v[g];
      assign bus.sub   = sub_v[g];
      assign bus.c_in  = cin_v[g];
      assign bus.a     = a_v[g][GN-1:0];
      assign bus.b     = b_v[g][GN-1:0];
      assign busy_v[g] = bus.busy;
      assign done_v[g] = bus.done;
      assign cout_v[g] = bus.c_out;
      assign ovf_v[g]  = bus.ovf;
      assign sum_v[g]  = 32'(bus.sum);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width add for sum/c_out, separate (n-1)-bit add for the MSB carry-in
   function automatic exp_t model(int unsigned n, logic s, logic ci, logic [31:0] a, logic [31:0] b);
      logic [31:0] mask, am, bm, lo;
      logic [32:0] full, part;
      logic        cin;
      exp_t        r;
      mask    = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      am      = a & mask;
      bm      = (s ? ~b : b) & mask;
      cin     = s ? 1'b1 : ci;
      full    = {1'b0, am} + {1'b0, bm} + {32'd0, cin};
      lo      = mask >> 1;
      part    = {1'b0, am & lo} + {1'b0, bm & lo} + {32'd0, cin};
      r.sum   = full[31:0] & mask;
      r.c_out = full[n];
      r.ovf   = part[n-1] ^ full[n];
      return r;
   endfunction

   // Issue one operation, scramble inputs (start included) while it runs, collect results.
   task automatic do_op(input int i, input logic s, input logic ci,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc, output logic tmo,
                        output logic extra_done, output logic [31:0] sum_o,
                        output logic co_o, output logic ov_o, output exp_t e);
      @(negedge clk);
      start_v[i] = 1'b1; sub_v[i] = s; cin_v[i] = ci; a_v[i] = a; b_v[i] = b;
      exp_q.push_back(model(cfg_n(i), s, ci, a, b));
      @(negedge clk);
      lat = 0; busy_cyc = 0; tmo = 1'b0;
      while (done_v[i] !== 1'b1 && !tmo) begin
         busy_cyc += (busy_v[i] === 1'b1) ? 1 : 0;
         start_v[i] = 1'b1;
         a_v[i] = $urandom; b_v[i] = $urandom;
         sub_v[i] = 1'($urandom); cin_v[i] = 1'($urandom);
         @(negedge clk);
         lat++;
         if (lat >= 200) tmo = 1'b1;
      end
      start_v[i] = 1'b0;
      sum_o = sum_v[i]; co_o = cout_v[i]; ov_o = ovf_v[i];
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      @(negedge clk);
      extra_done = done_v[i];
   endtask

   task automatic test_reset();
      for (int i = 0; i < NCFG; i++) begin
         n_checks++; if (busy_v[i] !== 1'b0) $display("FAIL reset_busy cfg%0d: got %b want 0", i, busy_v[i]); else n_pass++;
         n_checks++; if (done_v[i] !== 1'b0) $display("FAIL reset_done cfg%0d: got %b want 0", i, done_v[i]); else n_pass++;
         n_checks++; if (sum_v[i] !== 32'd0) $display("FAIL reset_sum cfg%0d: got %h want 0", i, sum_v[i]); else n_pass++;
         n_checks++; if (cout_v[i] !== 1'b0) $display("FAIL reset_cout cfg%0d: got %b want 0", i, cout_v[i]); else n_pass++;
         n_checks++; if (ovf_v[i] !== 1'b0) $display("FAIL reset_ovf cfg%0d: got %b want 0", i, ovf_v[i]); else n_pass++;
      end
   endtask

   task automatic test_add_w4();
      int lat, bc; logic tmo, xd, co, ov; logic [31:0] s; exp_t e;
      do_op(0, 1'b0, 1'b1, 32'h3C, 32'h45, lat, bc, tmo, xd, s, co, ov, e);
      n_checks++; if (tmo !== 1'b0) $display("FAIL add_timeout: got %b want 0", tmo); else n_pass++;
      n_checks++; if (lat != 2) $display("FAIL add_latency: got %0d want 2", lat); else n_pass++;
      n_checks++; if (bc != 1) $display("FAIL add_busy_cycles: got %0d want 1", bc); else n_pass++;
      n_checks++; if (s !== 32'h82) $display("FAIL add_sum: got %h want 82", s); else n_pass++;
      n_checks++; if (co !== 1'b0) $display("FAIL add_cout: got %b want 0", co); else n_pass++;
      n_checks++; if (ov !== 1'b1) $display("FAIL add_ovf: got %b want 1", ov); else n_pass++;
      n_checks++; if (xd !== 1'b0) $display("FAIL add_done_width: got %b want 0", xd); else n_pass++;
      n_checks++; if (s !== e.sum) $display("FAIL add_model_sum: got %h want %h", s, e.sum); else n_pass++;
   endtask

   task automatic test_carry_and_sub();
      int lat, bc; logic tmo, xd, co, ov; logic [31:0] s; exp_t e;
      logic [31:0] ta [3] = '{32'hFF, 32'h10, 32'h80};
      logic [31:0] tb [3] = '{32'h01, 32'h20, 32'h01};
      logic        ts [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] ws [3] = '{32'h00, 32'hF0, 32'h7F};
      logic        wc [3] = '{1'b1, 1'b0, 1'b1};
      logic        wo [3] = '{1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         do_op(0, ts[k], 1'b0, ta[k], tb[k], lat, bc, tmo, xd, s, co, ov, e);
         n_checks++; if (lat != 2) $display("FAIL cs%0d_latency: got %0d want 2", k, lat); else n_pass++;
         n_checks++; if (s !== ws[k]) $display("FAIL cs%0d_sum: got %h want %h", k, s, ws[k]); else n_pass++;
         n_checks++; if (co !== wc[k]) $display("FAIL cs%0d_cout: got %b want %b", k, co, wc[k]); else n_pass++;
         n_checks++; if (ov !== wo[k]) $display("FAIL cs%0d_ovf: got %b want %b", k, ov, wo[k]); else n_pass++;
      end
   endtask

   // N=8,W=2 with start held high and fresh operands every cycle: one accept per 5 edges.
   task automatic test_back_to_back();
      int p; exp_t e;
      logic [31:0] last_sum = 32'd0;
      logic last_co = 1'b0, last_ov = 1'b0;
      for (int j = 0; j <= 25; j++) begin
         @(negedge clk);
         if (j >= 1) begin
            p = (j - 1) % 5;
            n_checks++; if (done_v[1] !== 1'((p == 4))) $display("FAIL b2b_done j%0d: got %b want %b", j, done_v[1], (p == 4)); else n_pass++;
            n_checks++; if (busy_v[1] !== 1'((p >= 1) && (p <= 3))) $display("FAIL b2b_busy j%0d: got %b", j, busy_v[1]); else n_pass++;
            if (p == 4 && done_v[1] === 1'b1 && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               n_checks++; if (sum_v[1] !== e.sum) $display("FAIL b2b_sum j%0d: got %h want %h", j, sum_v[1], e.sum); else n_pass++;
               n_checks++; if ({cout_v[1], ovf_v[1]} !== {e.c_out, e.ovf}) $display("FAIL b2b_flags j%0d: got %b%b want %b%b", j, cout_v[1], ovf_v[1], e.c_out, e.ovf); else n_pass++;
               last_sum = e.sum; last_co = e.c_out; last_ov = e.ovf;
            end else begin
               n_checks++; if ({sum_v[1], cout_v[1], ovf_v[1]} !== {last_sum, last_co, last_ov}) $display("FAIL b2b_hold j%0d: got %h/%b%b want %h/%b%b", j, sum_v[1], cout_v[1], ovf_v[1], last_sum, last_co, last_ov); else n_pass++;
            end
         end
         if (j < 25) begin
            start_v[1] = 1'b1;
            a_v[1] = $urandom; b_v[1] = $urandom;
            sub_v[1] = 1'($urandom); cin_v[1] = 1'($urandom);
            if (j % 5 == 0) exp_q.push_back(model(8, sub_v[1], cin_v[1], a_v[1], b_v[1]));
         end else begin
            start_v[1] = 1'b0;
         end
      end
      n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int lat, bc; logic tmo, xd, co, ov; logic [31:0] s; exp_t e;
      @(negedge clk);
      start_v[2] = 1'b1; sub_v[2] = 1'b0; cin_v[2] = 1'b1;
      a_v[2] = 32'h8765_4321; b_v[2] = 32'h9ABC_DEF0;
      @(negedge clk);
      start_v[2] = 1'b0;
      @(negedge clk);
      n_checks++; if (busy_v[2] !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy_v[2]); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy_v[2] !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy_v[2]); else n_pass++;
      n_checks++; if ({done_v[2], cout_v[2], ovf_v[2]} !== 3'b000) $display("FAIL rmid_flags: got %b%b%b want 000", done_v[2], cout_v[2], ovf_v[2]); else n_pass++;
      n_checks++; if (sum_v[2] !== 32'd0) $display("FAIL rmid_sum: got %h want 0", sum_v[2]); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++; if ({done_v[2], busy_v[2]} !== 2'b00) $display("FAIL rmid_no_done k%0d: got %b%b want 00", k, done_v[2], busy_v[2]); else n_pass++;
      end
      do_op(2, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, lat, bc, tmo, xd, s, co, ov, e);
      n_checks++; if (lat != 4) $display("FAIL rmid_latency: got %0d want 4", lat); else n_pass++;
      n_checks++; if (s !== 32'h0001_0000) $display("FAIL rmid_sum_after: got %h want 00010000", s); else n_pass++;
      n_checks++; if ({co, ov} !== 2'b00) $display("FAIL rmid_flags_after: got %b%b want 00", co, ov); else n_pass++;
   endtask

   task automatic test_sweep();
      int lat, bc; logic tmo, xd, co, ov, rs, rc; logic [31:0] s, ra, rb; exp_t e;
      for (int i = 3; i < NCFG; i++) begin
         for (int k = 0; k < 1000; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
            if (k == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h1; rs = 1'b0; rc = 1'b1; end
            do_op(i, rs, rc, ra, rb, lat, bc, tmo, xd, s, co, ov, e);
            n_checks++; if (tmo !== 1'b0 || lat != int'(cfg_n(i) / cfg_w(i))) $display("FAIL sweep%0d_latency op%0d: got %0d want %0d", i, k, lat, cfg_n(i) / cfg_w(i)); else n_pass++;
            n_checks++; if (s !== e.sum) $display("FAIL sweep%0d_sum op%0d: got %h want %h", i, k, s, e.sum); else n_pass++;
            n_checks++; if ({co, ov} !== {e.c_out, e.ovf}) $display("FAIL sweep%0d_flags op%0d: got %b%b want %b%b", i, k, co, ov, e.c_out, e.ovf); else n_pass++;
            n_checks++; if (xd !== 1'b0) $display("FAIL sweep%0d_done_width op%0d: got %b want 0", i, k, xd); else n_pass++;
            if (i == 3) begin
               n_checks++; if (bc != 0) $display("FAIL sweep3_busy op%0d: got %0d want 0", k, bc); else n_pass++;
            end
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < NCFG; i++) begin
         start_v[i] = 1'b0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
         a_v[i] = 32'd0; b_v[i] = 32'd0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_add_w4();
      test_carry_and_sub();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
